// File: rtl/pb_noc_link_if.sv
// Bundle of per-channel valid/ready flit handshakes for one side of a pb_noc_link.
// The master drives valid and data. The slave drives ready.
interface pb_noc_link_if #(
   parameter int NumChannels = 3,
   parameter int FlitWidth   = 64
);

   logic [NumChannels-1:0]           valid;
   logic [NumChannels-1:0]           ready;
   logic [NumChannels*FlitWidth-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );

endinterface

// File: rtl/pb_noc_link.sv
// Buffered inter-tile NoC link. Each flit channel has its own small FIFO.
// A shared drain-then-isolate FSM lets a neighbouring tile be gated safely.
// Per-channel saturating counters track how many flits were delivered downstream.
module pb_noc_link #(
   parameter int NumChannels = 3,
   parameter int FlitWidth   = 64,
   parameter int Depth       = 2,
   parameter int CntWidth    = 32,
   parameter int FillWidth   = $clog2(Depth + 1)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            isolate_req_i,
   output logic                            isolated_o,
   input  logic                            clear_cnt_i,
   pb_noc_link_if.slave                    upstream,
   pb_noc_link_if.master                   downstream,
   output logic [NumChannels*FillWidth-1:0] fill_o,
   output logic [NumChannels*CntWidth-1:0]  flit_cnt_o
);

   localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

   // A single-entry FIFO cannot accept and deliver in the same cycle, so it would halve throughput.
   if (Depth < 2) begin : gen_depth_check
      $error("pb_noc_link: Depth must be at least 2");
   end

   typedef enum logic [1:0] {
      ST_ACTIVE,
      ST_DRAIN,
      ST_ISOLATED
   } state_e;

   state_e state;

   logic [NumChannels-1:0]           empty;
   logic [NumChannels-1:0]           full;
   logic [NumChannels-1:0]           in_ready;
   logic [NumChannels-1:0]           out_valid;
   logic [NumChannels*FlitWidth-1:0] out_data;
   logic                             all_empty;

   assign all_empty        = &empty;
   assign upstream.ready   = in_ready;
   assign downstream.valid = out_valid;
   assign downstream.data  = out_data;

   // Pointers wrap explicitly at Depth-1, so Depth does not have to be a power of two.
   function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] ptr);
      return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // Isolation handshake. Dropping the request during DRAIN wins over the drain completing.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_ACTIVE;
         isolated_o <= 1'b0;
      end else begin
         case (state)
            ST_ACTIVE: begin
               if (isolate_req_i) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!isolate_req_i) begin
                  state <= ST_ACTIVE;
               end else if (all_empty) begin
                  state      <= ST_ISOLATED;
                  isolated_o <= 1'b1;
               end
            end
            ST_ISOLATED: begin
               if (!isolate_req_i) begin
                  state      <= ST_ACTIVE;
                  isolated_o <= 1'b0;
               end
            end
            default: begin
               state      <= ST_ACTIVE;
               isolated_o <= 1'b0;
            end
         endcase
      end
   end

   for (genvar c = 0; c < NumChannels; c++) begin : gen_chan
      logic [FlitWidth-1:0] mem [Depth];
      logic [PtrWidth-1:0]  wr_ptr;
      logic [PtrWidth-1:0]  rd_ptr;
      logic [FillWidth-1:0] count;
      logic [CntWidth-1:0]  cnt;
      logic                 push;
      logic                 pop;

      assign empty[c] = (count == '0);
      assign full[c]  = (count == FillWidth'(Depth));

      // Ready depends only on local state and never on out_ready. A full FIFO refuses a flit
      // even when a pop happens in the same cycle.
      assign in_ready[c]  = !rst_i && !full[c] && (state == ST_ACTIVE);
      assign push         = upstream.valid[c] && in_ready[c];
      assign out_valid[c] = !empty[c] && (state != ST_ISOLATED);
      assign pop          = out_valid[c] && downstream.ready[c];

      assign out_data[c*FlitWidth +: FlitWidth] = mem[rd_ptr];
      assign fill_o[c*FillWidth +: FillWidth]   = count;
      assign flit_cnt_o[c*CntWidth +: CntWidth] = cnt;

      // FIFO bookkeeping. Reset discards buffered flits by clearing the pointers and occupancy.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
               rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end

      // Flit storage. It needs no reset because the occupancy count decides what is valid.
      always_ff @(posedge clk_i) begin
         if (push) begin
            mem[wr_ptr] <= upstream.data[c*FlitWidth +: FlitWidth];
         end
      end

      // Delivered-flit counter. It saturates instead of wrapping, and a clear beats a same-cycle increment.
      always_ff @(posedge clk_i) begin
         if (rst_i || clear_cnt_i) begin
            cnt <= '0;
         end else if (pop && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pb_noc_link.sv
// Self-checking bench for pb_noc_link.
// A second instance with 4-bit counters gets identical stimulus, so saturation shows up on it.
// A scoreboard queue per channel follows every accepted flit until it is delivered.
module tb_pb_noc_link;

   localparam int NC    = 3;
   localparam int FW    = 64;
   localparam int D     = 2;
   localparam int FILLW = 2;
   localparam int CW    = 32;
   localparam int SCW   = 4;

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic iso_req   = 1'b0;
   logic clear_cnt = 1'b0;

   logic              isolated;
   logic              isolated_s;
   logic [NC*FILLW-1:0] fill;
   logic [NC*FILLW-1:0] fill_s;
   logic [NC*CW-1:0]  cnt;
   logic [NC*SCW-1:0] cnt_s;

   pb_noc_link_if #(.NumChannels(NC), .FlitWidth(FW)) link_in ();
   pb_noc_link_if #(.NumChannels(NC), .FlitWidth(FW)) link_out ();
   pb_noc_link_if #(.NumChannels(NC), .FlitWidth(FW)) link_in_s ();
   pb_noc_link_if #(.NumChannels(NC), .FlitWidth(FW)) link_out_s ();

   assign link_in_s.valid  = link_in.valid;
   assign link_in_s.data   = link_in.data;
   assign link_out_s.ready = link_out.ready;

   pb_noc_link #(.NumChannels(NC), .FlitWidth(FW), .Depth(D), .CntWidth(CW)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .isolate_req_i (iso_req),
      .isolated_o    (isolated),
      .clear_cnt_i   (clear_cnt),
      .upstream      (link_in),
      .downstream    (link_out),
      .fill_o        (fill),
      .flit_cnt_o    (cnt)
   );

   pb_noc_link #(.NumChannels(NC), .FlitWidth(FW), .Depth(D), .CntWidth(SCW)) dut_sat (
      .clk_i         (clk),
      .rst_i         (rst),
      .isolate_req_i (iso_req),
      .isolated_o    (isolated_s),
      .clear_cnt_i   (clear_cnt),
      .upstream      (link_in_s),
      .downstream    (link_out_s),
      .fill_o        (fill_s),
      .flit_cnt_o    (cnt_s)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   typedef enum {M_ACT, M_DRAIN, M_ISO} mstate_t;
   mstate_t mstate = M_ACT;

   logic [FW-1:0]       exp_q [NC][$];
   logic [NC*CW-1:0]    exp_cnt   = '0;
   logic [NC*SCW-1:0]   exp_cnt_s = '0;
   logic [NC-1:0]       exp_ready;
   logic [NC-1:0]       exp_valid;
   logic [NC*FILLW-1:0] exp_fill;
   logic                all_empty_m;
   logic [NC-1:0]       popped;
   bit                  fired [NC];
   logic [55:0]         seq [NC];

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Each channel sends an incrementing sequence tagged with its channel number.
   // The sequence advances only after a flit has been accepted.
   initial begin : driver
      for (int c = 0; c < NC; c++) begin
         seq[c]   = '0;
         fired[c] = 1'b0;
         link_in.data[c*FW +: FW] = {8'(c), seq[c]};
      end
      forever begin
         @(posedge clk);
         #1;
         for (int c = 0; c < NC; c++) begin
            if (fired[c]) seq[c] = seq[c] + 1'b1;
            link_in.data[c*FW +: FW] = {8'(c), seq[c]};
         end
      end
   end

   // Reference model and scoreboard, sampled on the falling edge between active edges.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst) begin
            vectors++;
            if (link_in.ready !== '0 || link_in_s.ready !== '0) begin
               miscompares++;
               $display("[TB] FAIL ready_in_reset: got %b/%b, want 000", link_in.ready, link_in_s.ready);
            end
            for (int c = 0; c < NC; c++) begin
               exp_q[c].delete();
               fired[c] = 1'b0;
            end
            exp_cnt   = '0;
            exp_cnt_s = '0;
            mstate    = M_ACT;
         end else begin
            all_empty_m = 1'b1;
            for (int c = 0; c < NC; c++) begin
               exp_ready[c] = (mstate == M_ACT) && (exp_q[c].size() < D);
               exp_valid[c] = (exp_q[c].size() != 0);
               exp_fill[c*FILLW +: FILLW] = FILLW'(exp_q[c].size());
               if (exp_q[c].size() != 0) all_empty_m = 1'b0;
            end
            vectors++;
            if (link_in.ready !== exp_ready || link_in_s.ready !== exp_ready) begin
               miscompares++;
               $display("[TB] FAIL in_ready: got %b/%b, want %b", link_in.ready, link_in_s.ready, exp_ready);
            end
            vectors++;
            if (link_out.valid !== exp_valid || link_out_s.valid !== exp_valid) begin
               miscompares++;
               $display("[TB] FAIL out_valid: got %b/%b, want %b", link_out.valid, link_out_s.valid, exp_valid);
            end
            vectors++;
            if (fill !== exp_fill || fill_s !== exp_fill) begin
               miscompares++;
               $display("[TB] FAIL fill: got %b/%b, want %b", fill, fill_s, exp_fill);
            end
            vectors++;
            if (isolated !== (mstate == M_ISO) || isolated_s !== (mstate == M_ISO)) begin
               miscompares++;
               $display("[TB] FAIL isolated: got %b/%b, want %b", isolated, isolated_s, mstate == M_ISO);
            end
            vectors++;
            if (cnt !== exp_cnt || cnt_s !== exp_cnt_s) begin
               miscompares++;
               $display("[TB] FAIL flit_cnt: got %h/%h, want %h/%h", cnt, cnt_s, exp_cnt, exp_cnt_s);
            end
            for (int c = 0; c < NC; c++) begin
               popped[c] = link_out.valid[c] && link_out.ready[c];
               if (popped[c]) begin
                  vectors++;
                  if (exp_q[c].size() == 0) begin
                     miscompares++;
                     $display("[TB] FAIL spurious_flit ch%0d: got %h, want nothing", c, link_out.data[c*FW +: FW]);
                  end else begin
                     if (link_out.data[c*FW +: FW] !== exp_q[c][0] ||
                         link_out_s.data[c*FW +: FW] !== exp_q[c][0]) begin
                        miscompares++;
                        $display("[TB] FAIL flit_data ch%0d: got %h/%h, want %h", c,
                                 link_out.data[c*FW +: FW], link_out_s.data[c*FW +: FW], exp_q[c][0]);
                     end
                     void'(exp_q[c].pop_front());
                  end
               end
            end
            if (clear_cnt) begin
               exp_cnt   = '0;
               exp_cnt_s = '0;
            end else begin
               for (int c = 0; c < NC; c++) begin
                  if (popped[c] && exp_cnt[c*CW +: CW] != {CW{1'b1}})
                     exp_cnt[c*CW +: CW] = exp_cnt[c*CW +: CW] + 1'b1;
                  if (popped[c] && exp_cnt_s[c*SCW +: SCW] != {SCW{1'b1}})
                     exp_cnt_s[c*SCW +: SCW] = exp_cnt_s[c*SCW +: SCW] + 1'b1;
               end
            end
            for (int c = 0; c < NC; c++) begin
               fired[c] = link_in.valid[c] && exp_ready[c];
               if (fired[c]) exp_q[c].push_back(link_in.data[c*FW +: FW]);
            end
            case (mstate)
               M_ACT:   if (iso_req) mstate = M_DRAIN;
               M_DRAIN: if (!iso_req) mstate = M_ACT; else if (all_empty_m) mstate = M_ISO;
               M_ISO:   if (!iso_req) mstate = M_ACT;
               default: mstate = M_ACT;
            endcase
         end
      end
   end

   // Checks the first cycle after reset is released.
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      vectors++;
      if (link_in.ready !== 3'b111) begin
         miscompares++;
         $display("[TB] FAIL reset_release_ready: got %b, want 111", link_in.ready);
      end
      vectors++;
      if (fill !== '0 || link_out.valid !== '0 || isolated !== 1'b0 || cnt !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got fill=%b valid=%b iso=%b cnt=%h, want all zero",
                  fill, link_out.valid, isolated, cnt);
      end
   endtask

   // Streams 100 flits per channel with no backpressure.
   task automatic test_streaming();
      link_in.valid  = 3'b111;
      link_out.ready = 3'b111;
      repeat (100) tick();
      link_in.valid = 3'b000;
      repeat (3) tick();
      for (int c = 0; c < NC; c++) begin
         vectors++;
         if (cnt[c*CW +: CW] !== 32'd100 || cnt_s[c*SCW +: SCW] !== 4'd15) begin
            miscompares++;
            $display("[TB] FAIL stream_count ch%0d: got %0d/%0d, want 100/15", c,
                     cnt[c*CW +: CW], cnt_s[c*SCW +: SCW]);
         end
      end
   endtask

   // Stalls channel 1 while channels 0 and 2 keep streaming.
   task automatic test_backpressure();
      link_in.valid  = 3'b111;
      link_out.ready = 3'b101;
      repeat (10) tick();
      vectors++;
      if (fill !== 6'b01_10_01) begin
         miscompares++;
         $display("[TB] FAIL bp_fill: got %b, want 011001", fill);
      end
      vectors++;
      if (link_in.ready !== 3'b101) begin
         miscompares++;
         $display("[TB] FAIL bp_ready: got %b, want 101", link_in.ready);
      end
      link_in.valid  = 3'b000;
      link_out.ready = 3'b111;
      repeat (4) tick();
      vectors++;
      if (cnt[0 +: CW] !== 32'd110 || cnt[CW +: CW] !== 32'd102 || cnt[2*CW +: CW] !== 32'd110) begin
         miscompares++;
         $display("[TB] FAIL bp_count: got %0d/%0d/%0d, want 110/102/110",
                  cnt[0 +: CW], cnt[CW +: CW], cnt[2*CW +: CW]);
      end
   endtask

   // Drains buffered traffic and then isolates the link.
   task automatic test_isolation();
      link_out.ready = 3'b000;
      link_in.valid  = 3'b011;
      tick();
      link_in.valid = 3'b001;
      tick();
      link_in.valid = 3'b000;
      vectors++;
      if (fill !== 6'b00_01_10) begin
         miscompares++;
         $display("[TB] FAIL iso_prefill: got %b, want 000110", fill);
      end
      iso_req = 1'b1;
      tick();
      link_in.valid = 3'b111;
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (link_in.ready !== 3'b000 || isolated !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drain_hold%0d: got ready=%b iso=%b, want 000/0", i, link_in.ready, isolated);
         end
         if (i < 5) tick();
      end
      link_out.ready = 3'b111;
      tick();
      tick();
      vectors++;
      if (isolated !== 1'b0 || fill !== '0) begin
         miscompares++;
         $display("[TB] FAIL drain_empty: got iso=%b fill=%b, want 0/000000", isolated, fill);
      end
      tick();
      vectors++;
      if (isolated !== 1'b1 || link_out.valid !== 3'b000 || link_in.ready !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL isolated_entry: got iso=%b valid=%b ready=%b, want 1/000/000",
                  isolated, link_out.valid, link_in.ready);
      end
      iso_req       = 1'b0;
      link_in.valid = 3'b000;
      tick();
      vectors++;
      if (link_in.ready !== 3'b111 || isolated !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL iso_exit: got ready=%b iso=%b, want 111/0", link_in.ready, isolated);
      end
   endtask

   // A one-cycle isolate pulse must fall back to ACTIVE without losing any flit.
   task automatic test_abort_drain();
      link_out.ready = 3'b000;
      link_in.valid  = 3'b111;
      tick();
      link_in.valid = 3'b000;
      iso_req = 1'b1;
      tick();
      iso_req = 1'b0;
      vectors++;
      if (link_in.ready !== 3'b000 || isolated !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_drain: got ready=%b iso=%b, want 000/0", link_in.ready, isolated);
      end
      tick();
      vectors++;
      if (link_in.ready !== 3'b111 || fill !== 6'b01_01_01) begin
         miscompares++;
         $display("[TB] FAIL abort_active: got ready=%b fill=%b, want 111/010101", link_in.ready, fill);
      end
      link_out.ready = 3'b111;
      repeat (3) tick();
      vectors++;
      if (cnt[0 +: CW] !== 32'd113 || cnt[CW +: CW] !== 32'd104 || cnt[2*CW +: CW] !== 32'd111) begin
         miscompares++;
         $display("[TB] FAIL abort_count: got %0d/%0d/%0d, want 113/104/111",
                  cnt[0 +: CW], cnt[CW +: CW], cnt[2*CW +: CW]);
      end
   endtask

   // A clear in the same cycle as a delivery wins. The following flit then counts as 1.
   task automatic test_counter_clear();
      link_out.ready = 3'b111;
      link_in.valid  = 3'b001;
      repeat (3) tick();
      link_in.valid = 3'b000;
      vectors++;
      if (link_out.valid[0] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL clear_setup: got valid0=%b, want 1", link_out.valid[0]);
      end
      clear_cnt = 1'b1;
      tick();
      clear_cnt = 1'b0;
      vectors++;
      if (cnt !== '0 || cnt_s !== '0 || link_out.valid[0] !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL clear_wins: got cnt=%h sat=%h valid0=%b, want 0/0/0", cnt, cnt_s, link_out.valid[0]);
      end
      link_in.valid = 3'b001;
      tick();
      link_in.valid = 3'b000;
      tick();
      vectors++;
      if (cnt[0 +: CW] !== 32'd1 || cnt_s[0 +: SCW] !== 4'd1 || cnt[CW +: CW] !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL clear_next: got %0d/%0d/%0d, want 1/1/0", cnt[0 +: CW], cnt_s[0 +: SCW], cnt[CW +: CW]);
      end
   endtask

   // Reset with every FIFO full. No pre-reset flit may reappear afterwards.
   task automatic test_reset_mid();
      link_out.ready = 3'b000;
      link_in.valid  = 3'b111;
      repeat (3) tick();
      vectors++;
      if (fill !== 6'b10_10_10 || link_in.ready !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL full_before_reset: got fill=%b ready=%b, want 101010/000", fill, link_in.ready);
      end
      rst            = 1'b1;
      link_out.ready = 3'b111;
      tick();
      rst           = 1'b0;
      link_in.valid = 3'b000;
      #1;
      vectors++;
      if (fill !== '0 || link_out.valid !== '0 || cnt !== '0 || cnt_s !== '0 ||
          isolated !== 1'b0 || link_in.ready !== 3'b111) begin
         miscompares++;
         $display("[TB] FAIL mid_reset: got fill=%b valid=%b cnt=%h iso=%b ready=%b, want 0/0/0/0/111",
                  fill, link_out.valid, cnt, isolated, link_in.ready);
      end
      repeat (3) tick();
      vectors++;
      if (link_out.valid !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL stale_flit: got valid=%b, want 000", link_out.valid);
      end
   endtask

   // Runs the scenarios in order and then prints the summary.
   initial begin : main
      link_in.valid  = 3'b000;
      link_out.ready = 3'b000;
      test_reset();
      test_streaming();
      test_backpressure();
      test_isolation();
      test_abort_drain();
      test_counter_clear();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Stops a hung simulation.
   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
